orao_autotype: RTL and testbench

//  Scripted power-up key sequencer that sits directly upstream of the orao computer core.

---
 rtl/orao_autotype_if.sv | 40 ++++
 rtl/orao_autotype.sv | 129 ++++++++++++
 tb/tb_orao_autotype.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/orao_autotype_if.sv
// Key/reset bundle between the autotype sequencer (master) and the orao core side (slave).
// abort exists only when ORAO_AUTOTYPE_ABORT_EN is defined.
interface orao_autotype_if;
    logic start;
`ifdef ORAO_AUTOTYPE_ABORT_EN
    logic abort;
`endif
    logic sys_n_reset;
    logic key_b;
    logic key_c;
    logic key_enter;
    logic busy;
    logic done;

    modport master (
        input  start,
`ifdef ORAO_AUTOTYPE_ABORT_EN
        input  abort,
`endif
        output sys_n_reset,
        output key_b,
        output key_c,
        output key_enter,
        output busy,
        output done
    );

    modport slave (
        output start,
`ifdef ORAO_AUTOTYPE_ABORT_EN
        output abort,
`endif
        input  sys_n_reset,
        input  key_b,
        input  key_c,
        input  key_enter,
        input  busy,
        input  done
    );
endinterface

// File: rtl/orao_autotype.sv
// Power-up sequencer: holds the orao core in reset, then types B, C, ENTER x3; outputs registered, no backpressure.
// Optional abort input (stop typing, go to done) under ORAO_AUTOTYPE_ABORT_EN.
module orao_autotype #(
    parameter int RESET_CYC = 12500000,
    parameter int PRESS_CYC = 12500000,
    parameter int GAP_CYC   = 25000000
) (
    input  logic            clk,
    input  logic            n_reset,
    orao_autotype_if.master io
);
    localparam int MAX_RP  = (RESET_CYC > PRESS_CYC) ? RESET_CYC : PRESS_CYC;
    localparam int MAX_CYC = (MAX_RP > GAP_CYC) ? MAX_RP : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RESET_LD = CW'(RESET_CYC - 1);
    localparam logic [CW-1:0] PRESS_LD = CW'(PRESS_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [2:0]    STEP_END = 3'd6;

    typedef enum logic [1:0] {RST_HOLD, PRESS, GAP, DONE} state_t;
    typedef enum logic [2:0] {OP_RESET, OP_KEY_B, OP_KEY_C, OP_KEY_ENTER, OP_END} op_t;

    function automatic op_t script_rom(input logic [2:0] s);
        case (s)
            3'd0:    script_rom = OP_RESET;
            3'd1:    script_rom = OP_KEY_B;
            3'd2:    script_rom = OP_KEY_C;
            3'd3:    script_rom = OP_KEY_ENTER;
            3'd4:    script_rom = OP_KEY_ENTER;
            3'd5:    script_rom = OP_KEY_ENTER;
            default: script_rom = OP_END;
        endcase
    endfunction

    state_t          state;
    logic [2:0]      step;
    logic [CW-1:0]   cnt;
    logic [2:0]      next_step;
    op_t             next_op;
    logic            abort_req;

    always_comb begin
        next_step = (step == STEP_END) ? STEP_END : step + 3'd1;
        next_op   = script_rom(next_step);
    end

`ifdef ORAO_AUTOTYPE_ABORT_EN
    assign abort_req = io.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state          <= RST_HOLD;
            step           <= 3'd0;
            cnt            <= RESET_LD;
            io.sys_n_reset <= 1'b0;
            io.key_b       <= 1'b0;
            io.key_c       <= 1'b0;
            io.key_enter   <= 1'b0;
            io.busy        <= 1'b1;
            io.done        <= 1'b0;
        end else if (state == DONE) begin
            if (io.start) begin
                state          <= RST_HOLD;
                step           <= 3'd0;
                cnt            <= RESET_LD;
                io.sys_n_reset <= 1'b0;
                io.busy        <= 1'b1;
                io.done        <= 1'b0;
            end
        end else if (abort_req) begin
            // Abort wins over a phase boundary falling on the same edge.
            state          <= DONE;
            step           <= STEP_END;
            io.sys_n_reset <= 1'b1;
            io.key_b       <= 1'b0;
            io.key_c       <= 1'b0;
            io.key_enter   <= 1'b0;
            io.busy        <= 1'b0;
            io.done        <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            case (state)
                RST_HOLD: begin
                    state          <= GAP;
                    cnt            <= GAP_LD;
                    io.sys_n_reset <= 1'b1;
                end
                PRESS: begin
                    state        <= GAP;
                    cnt          <= GAP_LD;
                    io.key_b     <= 1'b0;
                    io.key_c     <= 1'b0;
                    io.key_enter <= 1'b0;
                end
                GAP: begin
                    step <= next_step;
                    case (next_op)
                        OP_KEY_B: begin
                            state    <= PRESS;
                            cnt      <= PRESS_LD;
                            io.key_b <= 1'b1;
                        end
                        OP_KEY_C: begin
                            state    <= PRESS;
                            cnt      <= PRESS_LD;
                            io.key_c <= 1'b1;
                        end
                        OP_KEY_ENTER: begin
                            state        <= PRESS;
                            cnt          <= PRESS_LD;
                            io.key_enter <= 1'b1;
                        end
                        default: begin
                            state   <= DONE;
                            io.busy <= 1'b0;
                            io.done <= 1'b1;
                        end
                    endcase
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_orao_autotype.sv
// Scoreboarded timeline bench for orao_autotype with short phase lengths.
// Abort scenario is exercised only when ORAO_AUTOTYPE_ABORT_EN is defined.
module tb_orao_autotype;
    localparam int R = 4;
    localparam int P = 3;
    localparam int G = 2;
    localparam int DONE_N = R + 5 * (G + P) + G;

    localparam logic [5:0] V_RST  = 6'b000010;
    localparam logic [5:0] V_DONE = 6'b100001;

    logic clk     = 1'b0;
    logic n_reset = 1'b1;
    bit   clk_run = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    int m_n  = 0;
    bit m_ab = 1'b0;
    logic [5:0] exp_q[$];

    orao_autotype_if io();

    orao_autotype #(
        .RESET_CYC(R),
        .PRESS_CYC(P),
        .GAP_CYC  (G)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .io     (io)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [5:0] outs();
        return {io.sys_n_reset, io.key_b, io.key_c, io.key_enter, io.busy, io.done};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected outputs from position n within the script: phases laid end to end.
    function automatic logic [5:0] model_out(input int n, input bit ab);
        int t, k, r;
        if (ab) return V_DONE;
        if (n < R) return V_RST;
        t = n - R;
        if (t >= 5 * (G + P) + G) return V_DONE;
        k = t / (G + P);
        r = t % (G + P);
        if (r < G) return 6'b100010;
        case (k)
            0:       return 6'b110010;
            1:       return 6'b101010;
            default: return 6'b100110;
        endcase
    endfunction

    task automatic step(input bit st, input bit ab);
        io.start = st;
`ifdef ORAO_AUTOTYPE_ABORT_EN
        io.abort = ab;
`endif
        if (m_ab || m_n >= DONE_N) begin
            if (st) begin
                m_n  = 0;
                m_ab = 1'b0;
            end
        end else if (ab) begin
            m_ab = 1'b1;
        end else begin
            m_n++;
        end
        exp_q.push_back(model_out(m_n, m_ab));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) chk("sb_empty", 8'd0, 8'd1);
        else chk($sformatf("timeline_n%0d", m_n), {2'b00, outs()}, {2'b00, exp_q.pop_front()});
        @(negedge clk);
        io.start = 1'b0;
`ifdef ORAO_AUTOTYPE_ABORT_EN
        io.abort = 1'b0;
`endif
    endtask

    // Called at a negedge: asynchronous assert, check between edges, release before next edge.
    task automatic pulse_reset(input string tag);
        n_reset = 1'b0;
        #1;
        chk(tag, {2'b00, outs()}, {2'b00, V_RST});
        #1;
        n_reset = 1'b1;
        m_n  = 0;
        m_ab = 1'b0;
    endtask

    always @(negedge clk) begin
        if (clk_run && n_reset === 1'b1) begin
            chk("onehot_keys", {7'd0, $onehot0({io.key_b, io.key_c, io.key_enter})}, 8'd1);
            chk("key_in_reset",
                {7'd0, !((io.key_b | io.key_c | io.key_enter) && !io.sys_n_reset)}, 8'd1);
        end
    end

    initial begin
        io.start = 1'b0;
`ifdef ORAO_AUTOTYPE_ABORT_EN
        io.abort = 1'b0;
`endif
        #2;
        n_reset = 1'b0;
        #1;
        chk("rst_noclk", {2'b00, outs()}, {2'b00, V_RST});
        #20;
        chk("rst_noclk_hold", {2'b00, outs()}, {2'b00, V_RST});
        clk_run = 1'b1;
        @(negedge clk);
        n_reset = 1'b1;
        m_n  = 0;
        m_ab = 1'b0;

        // Full script; start while busy is ignored, start while done replays.
        for (int i = 1; i <= 35; i++) step(i == 8 || i == 35, 1'b0);
        for (int i = 1; i <= 40; i++) step(1'b0, 1'b0);
        // Level-held start in done keeps restarting.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("restart_busy", {7'd0, io.busy}, 8'd1);

        // Mid-script reset during key_c replays from scratch.
        pulse_reset("rst_pre");
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0);
        chk("key_c_before_abort_rst", {7'd0, io.key_c}, 8'd1);
        pulse_reset("rst_mid_key_c");
        for (int i = 1; i <= 36; i++) step(1'b0, 1'b0);

`ifdef ORAO_AUTOTYPE_ABORT_EN
        pulse_reset("rst_abort");
        for (int i = 1; i <= 17; i++) step(1'b0, i == 17);
        chk("abort_done", {2'b00, outs()}, {2'b00, V_DONE});
        for (int i = 1; i <= 20; i++) step(1'b0, i[0]);
        step(1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
